// File: rtl/usu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : usu_pkg
//  Description : Op-code constants, FSM state encoding and helpers for the
//                universal shift unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package usu_pkg;

    localparam logic [2:0] OP_HOLD = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_SHL  = 3'd2;
    localparam logic [2:0] OP_SHR  = 3'd3;
    localparam logic [2:0] OP_ASR  = 3'd4;
    localparam logic [2:0] OP_ROL  = 3'd5;
    localparam logic [2:0] OP_ROR  = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic is_shift_op(input logic [2:0] op);
        return (op >= OP_SHL) && (op <= OP_ROR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/usu_shift_step.sv
`default_nettype none
// ============================================================================
//  Module      : usu_shift_step
//  Description : Combinational single-bit step of a shift/rotate operation.
//  Revision    : 1.0 - initial release
// ============================================================================
module usu_shift_step
    import usu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_reg,
    input  logic [2:0]       i_op,
    input  logic             i_fill,
    output logic [WIDTH-1:0] o_reg,
    output logic             o_bit
);

    always_comb begin
        o_reg = i_reg;
        o_bit = 1'b0;
        case (i_op)
            OP_SHL: begin
                o_reg = {i_reg[WIDTH-2:0], i_fill};
                o_bit = i_reg[WIDTH-1];
            end
            OP_SHR: begin
                o_reg = {i_fill, i_reg[WIDTH-1:1]};
                o_bit = i_reg[0];
            end
            OP_ASR: begin
                o_reg = {i_reg[WIDTH-1], i_reg[WIDTH-1:1]};
                o_bit = i_reg[0];
            end
            OP_ROL: begin
                o_reg = {i_reg[WIDTH-2:0], i_reg[WIDTH-1]};
                o_bit = i_reg[WIDTH-1];
            end
            OP_ROR: begin
                o_reg = {i_reg[0], i_reg[WIDTH-1:1]};
                o_bit = i_reg[0];
            end
            default: begin
                o_reg = i_reg;
                o_bit = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/universal_shift_unit.sv
`default_nettype none
// ============================================================================
//  Module      : universal_shift_unit
//  Description : Command-driven shift register performing multi-bit shifts and
//                rotates one bit per cycle, with valid/ready handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module universal_shift_unit
    import usu_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int SAW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [SAW-1:0]   cmd_shamt,
    input  logic [WIDTH-1:0] data_in,
    input  logic             serial_in,
    output logic [WIDTH-1:0] reg_out,
    output logic             serial_out,
    output logic             res_valid,
    input  logic             res_ready
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] reg_q, reg_d;
    logic             sout_q, sout_d;
    logic [SAW-1:0]   cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic             fill_q, fill_d;

    logic [WIDTH-1:0] w_step_reg;
    logic             w_step_bit;

    usu_shift_step #(.WIDTH(WIDTH)) u_step (
        .i_reg  (reg_q),
        .i_op   (op_q),
        .i_fill (fill_q),
        .o_reg  (w_step_reg),
        .o_bit  (w_step_bit)
    );

    always_comb begin
        state_d = state_q;
        reg_d   = reg_q;
        sout_d  = sout_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        fill_d  = fill_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_op == OP_LOAD) begin
                        reg_d   = data_in;
                        state_d = ST_DONE;
                    end else if (is_shift_op(cmd_op) && (cmd_shamt != '0)) begin
                        // Op and fill bit are captured so later pin activity is ignored
                        op_d    = cmd_op;
                        fill_d  = serial_in;
                        cnt_d   = cmd_shamt;
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                reg_d  = w_step_reg;
                sout_d = w_step_bit;
                cnt_d  = cnt_q - SAW'(1);
                if (cnt_q == SAW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            reg_q   <= '0;
            sout_q  <= 1'b0;
            cnt_q   <= '0;
            op_q    <= OP_HOLD;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            sout_q  <= sout_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            fill_q  <= fill_d;
        end
    end

    assign cmd_ready  = (state_q == ST_IDLE);
    assign res_valid  = (state_q == ST_DONE);
    assign reg_out    = reg_q;
    assign serial_out = sout_q;

endmodule
`default_nettype wire
